// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: FSM states, opcode width and opcode values.
package acc_cpu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT_WAIT,
        HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
    localparam logic [OP_W-1:0] OP_LDI  = 5'h01;
    localparam logic [OP_W-1:0] OP_ADD  = 5'h02;
    localparam logic [OP_W-1:0] OP_SUB  = 5'h03;
    localparam logic [OP_W-1:0] OP_AND  = 5'h04;
    localparam logic [OP_W-1:0] OP_OR   = 5'h05;
    localparam logic [OP_W-1:0] OP_XOR  = 5'h06;
    localparam logic [OP_W-1:0] OP_SHL  = 5'h07;
    localparam logic [OP_W-1:0] OP_SHR  = 5'h08;
    localparam logic [OP_W-1:0] OP_CMP  = 5'h09;
    localparam logic [OP_W-1:0] OP_JMP  = 5'h0A;
    localparam logic [OP_W-1:0] OP_JZ   = 5'h0B;
    localparam logic [OP_W-1:0] OP_JNZ  = 5'h0C;
    localparam logic [OP_W-1:0] OP_JC   = 5'h0D;
    localparam logic [OP_W-1:0] OP_ST   = 5'h0E;
    localparam logic [OP_W-1:0] OP_LD   = 5'h0F;
    localparam logic [OP_W-1:0] OP_OUT  = 5'h10;
    localparam logic [OP_W-1:0] OP_CALL = 5'h11;
    localparam logic [OP_W-1:0] OP_RET  = 5'h12;
    localparam logic [OP_W-1:0] OP_ADC  = 5'h13;
    localparam logic [OP_W-1:0] OP_HALT = 5'h14;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the accumulator result and new flags for arithmetic,
// logic, shift and compare opcodes. Non-ALU opcodes pass acc and carry through.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              carry_in,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              writes_acc
);

    logic [DATA_W:0] sum;

    // Result and flag selection per opcode; zero is compare-equal for CMP, result==0 otherwise.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result     = acc;
        carry      = carry_in;
        writes_acc = 1'b0;
        sum        = '0;
        case (opcode)
            OP_LDI: begin
                result     = operand;
                writes_acc = 1'b1;
            end
            OP_ADD, OP_ADC: begin
                sum = {1'b0, acc} + {1'b0, operand}
                    + {{DATA_W{1'b0}}, (opcode == OP_ADC) && carry_in};
                result     = sum[DATA_W-1:0];
                carry      = sum[DATA_W];
                writes_acc = 1'b1;
            end
            OP_SUB: begin
                result     = acc - operand;
                carry      = acc < operand;
                writes_acc = 1'b1;
            end
            OP_AND: begin
                result     = acc & operand;
                carry      = 1'b0;
                writes_acc = 1'b1;
            end
            OP_OR: begin
                result     = acc | operand;
                carry      = 1'b0;
                writes_acc = 1'b1;
            end
            OP_XOR: begin
                result     = acc ^ operand;
                carry      = 1'b0;
                writes_acc = 1'b1;
            end
            OP_SHL: begin
                result     = {acc[DATA_W-2:0], 1'b0};
                carry      = acc[DATA_W-1];
                writes_acc = 1'b1;
            end
            OP_SHR: begin
                result     = {1'b0, acc[DATA_W-1:1]};
                carry      = acc[0];
                writes_acc = 1'b1;
            end
            OP_CMP: begin
                carry = acc < operand;
            end
            default: ;
        endcase
        zero = (opcode == OP_CMP) ? (acc == operand) : (result == '0);
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: loadable instruction memory, data memory, return stack and the
// IDLE/FETCH/EXEC/OUT_WAIT/HALT control FSM with a valid/ready output port.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   soft_clr,
    input  logic                   run,
    input  logic                   step,
    input  logic                   prog_we,
    input  logic [ADDR_W-1:0]      prog_addr,
    input  logic [OP_W+DATA_W-1:0] prog_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [DATA_W-1:0]      acc,
    output logic [ADDR_W-1:0]      pc,
    output logic                   zero,
    output logic                   carry,
    output logic                   halted,
    output logic                   fault,
    output logic                   busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [OP_W+DATA_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0]      dmem [DEPTH];
    logic [ADDR_W-1:0]      ret_stack [STACK_DEPTH];

    state_t            state;
    logic [OP_W-1:0]   ir_op;
    logic [DATA_W-1:0] ir_opd;
    logic [SP_W-1:0]   sp;

    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              stack_full;
    logic              stack_empty;
    logic              illegal;
    logic              exec_now;
    state_t            next_run;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_we;

    assign ir_addr     = ir_opd[ADDR_W-1:0];
    assign pc_inc      = pc + ADDR_W'(1);
    assign sp_dec      = sp - SP_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign illegal     = (ir_op > OP_HALT);
    assign exec_now    = (state == EXEC) && !soft_clr;
    assign next_run    = (run || step) ? FETCH : IDLE;
    assign busy        = (state != IDLE) && (state != HALT);

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .acc        (acc),
        .operand    (ir_opd),
        .carry_in   (carry),
        .opcode     (ir_op),
        .result     (alu_result),
        .zero       (alu_zero),
        .carry      (alu_carry),
        .writes_acc (alu_we)
    );

    // Storage writes: program load (only while stopped), ST to data memory, CALL push.
    // NOTE: memories have no reset so they map to RAM and survive rst_n and soft_clr.
    always_ff @(posedge clk) begin
        if (prog_we && !soft_clr && (state == IDLE || state == HALT))
            imem[prog_addr] <= prog_wdata;
        if (exec_now && ir_op == OP_ST)
            dmem[ir_addr] <= acc;
        if (exec_now && ir_op == OP_CALL && !stack_full)
            ret_stack[sp[IDX_W-1:0]] <= pc_inc;
    end

    // Control FSM and all architectural registers; soft_clr outranks every other input.
    // NOTE: state registers use non-blocking assignments so each reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir_op     <= OP_NOP;
            ir_opd    <= '0;
            acc       <= '0;
            pc        <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sp        <= '0;
        end else if (soft_clr) begin
            state     <= IDLE;
            ir_op     <= OP_NOP;
            ir_opd    <= '0;
            acc       <= '0;
            pc        <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sp        <= '0;
        end else begin
            case (state)
                IDLE: if (run || step) state <= FETCH;
                FETCH: begin
                    {ir_op, ir_opd} <= imem[pc];
                    state           <= EXEC;
                end
                EXEC: begin
                    state <= next_run;
                    pc    <= pc_inc;
                    if (illegal) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= HALT;
                        pc     <= pc;
                    end else begin
                        case (ir_op)
                            OP_JMP: pc <= ir_addr;
                            OP_JZ:  if (zero)  pc <= ir_addr;
                            OP_JNZ: if (!zero) pc <= ir_addr;
                            OP_JC:  if (carry) pc <= ir_addr;
                            OP_ST:  ;
                            OP_LD: begin
                                acc  <= dmem[ir_addr];
                                zero <= (dmem[ir_addr] == '0);
                            end
                            OP_OUT: begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                                state     <= OUT_WAIT;
                            end
                            OP_CALL: begin
                                if (stack_full) begin
                                    fault  <= 1'b1;
                                    halted <= 1'b1;
                                    state  <= HALT;
                                    pc     <= pc;
                                end else begin
                                    sp <= sp + SP_W'(1);
                                    pc <= ir_addr;
                                end
                            end
                            OP_RET: begin
                                if (stack_empty) begin
                                    fault  <= 1'b1;
                                    halted <= 1'b1;
                                    state  <= HALT;
                                    pc     <= pc;
                                end else begin
                                    sp <= sp_dec;
                                    pc <= ret_stack[sp_dec[IDX_W-1:0]];
                                end
                            end
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= HALT;
                                pc     <= pc;
                            end
                            default: begin
                                if (alu_we) acc <= alu_result;
                                if (alu_we || ir_op == OP_CMP) zero <= alu_zero;
                                carry <= alu_carry;
                            end
                        endcase
                    end
                end
                OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= next_run;
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: an instruction-level model of the ISA plus a
// timing wrapper is compared against the core every cycle, with literal spot checks.
module tb_acc_cpu_core;
    import acc_cpu_pkg::*;

    localparam int STK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_clr = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [12:0] prog_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [7:0]  acc;
    logic [3:0]  pc;
    logic        zero, carry, halted, fault, busy;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4), .STACK_DEPTH(STK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_clr   (soft_clr),
        .run        (run),
        .step       (step),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .acc        (acc),
        .pc         (pc),
        .zero       (zero),
        .carry      (carry),
        .halted     (halted),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- model ----------------
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_OUTW = 3, M_HALT = 4;
    int          m_acc, m_pc, m_zero, m_carry, m_halted, m_fault, m_ov, m_od, m_mode;
    logic [12:0] m_imem [16];
    int          m_dmem [16];
    int          m_stack [$];
    logic [12:0] m_ir;

    task automatic m_reset();
        m_acc = 0; m_pc = 0; m_zero = 0; m_carry = 0; m_halted = 0;
        m_fault = 0; m_ov = 0; m_od = 0; m_mode = M_IDLE;
        m_stack.delete();
    endtask

    task automatic m_set_acc(input int v);
        m_acc  = v;
        m_zero = (v == 0);
    endtask

    task automatic m_execute();
        int  op, v, a, s, npc;
        bit  stop;
        op   = int'(m_ir[12:8]);
        v    = int'(m_ir[7:0]);
        a    = v % 16;
        npc  = (m_pc + 1) % 16;
        stop = 1'b0;
        m_mode = (run || step) ? M_FETCH : M_IDLE;
        case (op)
            0:  ;
            1:  m_set_acc(v);
            2:  begin s = m_acc + v; m_carry = (s > 255); m_set_acc(s % 256); end
            3:  begin m_carry = (m_acc < v); m_set_acc((m_acc - v + 256) % 256); end
            4:  begin m_carry = 0; m_set_acc(m_acc & v); end
            5:  begin m_carry = 0; m_set_acc(m_acc | v); end
            6:  begin m_carry = 0; m_set_acc(m_acc ^ v); end
            7:  begin m_carry = m_acc / 128; m_set_acc((m_acc * 2) % 256); end
            8:  begin m_carry = m_acc % 2; m_set_acc(m_acc / 2); end
            9:  begin m_zero = (m_acc == v); m_carry = (m_acc < v); end
            10: npc = a;
            11: if (m_zero != 0) npc = a;
            12: if (m_zero == 0) npc = a;
            13: if (m_carry != 0) npc = a;
            14: m_dmem[a] = m_acc;
            15: m_set_acc(m_dmem[a]);
            16: begin m_od = m_acc; m_ov = 1; m_mode = M_OUTW; end
            17: if (m_stack.size() == STK) stop = 1'b1;
                else begin m_stack.push_back(npc); npc = a; end
            18: if (m_stack.size() == 0) stop = 1'b1;
                else npc = m_stack.pop_back();
            19: begin s = m_acc + v + m_carry; m_carry = (s > 255); m_set_acc(s % 256); end
            20: begin m_halted = 1; m_mode = M_HALT; npc = m_pc; end
            default: stop = 1'b1;
        endcase
        if (stop) begin
            m_fault = 1; m_halted = 1; m_mode = M_HALT; npc = m_pc;
        end
        m_pc = npc;
    endtask

    // Model timing: two cycles per instruction, output waits for out_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || soft_clr) begin
            m_reset();
        end else begin
            if (prog_we && (m_mode == M_IDLE || m_mode == M_HALT))
                m_imem[prog_addr] = prog_wdata;
            case (m_mode)
                M_IDLE:  if (run || step) m_mode = M_FETCH;
                M_FETCH: begin m_ir = m_imem[m_pc]; m_mode = M_EXEC; end
                M_EXEC:  m_execute();
                M_OUTW:  if (out_ready) begin m_ov = 0; m_mode = (run || step) ? M_FETCH : M_IDLE; end
                default: ;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("acc",       32'(acc),       m_acc);
            check("pc",        32'(pc),        m_pc);
            check("zero",      32'(zero),      m_zero);
            check("carry",     32'(carry),     m_carry);
            check("halted",    32'(halted),    m_halted);
            check("fault",     32'(fault),     m_fault);
            check("out_valid", 32'(out_valid), m_ov);
            check("out_data",  32'(out_data),  m_od);
            check("busy",      32'(busy),      32'((m_mode != M_IDLE) && (m_mode != M_HALT)));
        end
    end

    // ---------------- stimulus ----------------
    logic [12:0] prog [16];

    function automatic logic [12:0] ins(input logic [4:0] op, input logic [7:0] v);
        return {op, v};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = ins(OP_HALT, 8'h00);
    endtask

    // Load the whole program while stopped, then soft-clear to restart at pc 0.
    task automatic load_and_clear();
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 4'(i);
            prog_wdata = prog[i];
            tick();
        end
        prog_we  = 1'b0;
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (halted !== 1'b1 && n < 200) begin tick(); n++; end
        check(name, 32'(halted), 1);
        run = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
        check(name, 32'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        tick(); tick(); tick();
        check("rst_acc", 32'(acc), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // LDI F0, ADD 20, OUT, HALT
        clear_prog();
        prog[0] = ins(OP_LDI, 8'hF0);
        prog[1] = ins(OP_ADD, 8'h20);
        prog[2] = ins(OP_OUT, 8'h00);
        prog[3] = ins(OP_HALT, 8'h00);
        load_and_clear();
        out_ready = 1'b1;
        run = 1'b1;
        wait_halt("add_halt");
        check("add_out_data", 32'(out_data), 32'h10);
        check("add_carry", 32'(carry), 1);
        check("add_pc", 32'(pc), 3);

        // CMP / JZ then SUB borrow
        clear_prog();
        prog[0] = ins(OP_LDI, 8'd5);
        prog[1] = ins(OP_CMP, 8'd5);
        prog[2] = ins(OP_JZ, 8'd6);
        prog[6] = ins(OP_LDI, 8'd3);
        prog[7] = ins(OP_SUB, 8'd4);
        load_and_clear();
        run = 1'b1;
        n = 0;
        while (pc !== 4'd6 && n < 50) begin tick(); n++; end
        check("jz_pc", 32'(pc), 6);
        check("cmp_zero", 32'(zero), 1);
        check("cmp_carry", 32'(carry), 0);
        wait_halt("sub_halt");
        check("sub_acc", 32'(acc), 32'hFF);
        check("sub_carry", 32'(carry), 1);

        // Shifts, ADC, logic ops, ST/LD, JNZ taken, JC not taken
        clear_prog();
        prog[0]  = ins(OP_LDI, 8'h81);
        prog[1]  = ins(OP_SHL, 8'h00);
        prog[2]  = ins(OP_ADC, 8'h10);
        prog[3]  = ins(OP_ST,  8'd5);
        prog[4]  = ins(OP_XOR, 8'h13);
        prog[5]  = ins(OP_LD,  8'd5);
        prog[6]  = ins(OP_SHR, 8'h00);
        prog[7]  = ins(OP_OR,  8'h40);
        prog[8]  = ins(OP_AND, 8'h0F);
        prog[9]  = ins(OP_JNZ, 8'd11);
        prog[11] = ins(OP_JC,  8'd13);
        prog[13] = ins(OP_LDI, 8'hEE);
        load_and_clear();
        run = 1'b1;
        wait_halt("mix_halt");
        check("mix_acc", 32'(acc), 32'h09);
        check("mix_pc", 32'(pc), 12);

        // CALL / RET returns to caller + 1
        clear_prog();
        prog[0] = ins(OP_CALL, 8'd8);
        prog[8] = ins(OP_RET, 8'h00);
        load_and_clear();
        run = 1'b1;
        wait_halt("ret_halt");
        check("ret_pc", 32'(pc), 1);
        check("ret_fault", 32'(fault), 0);

        // Third nested CALL overflows a two-entry stack
        clear_prog();
        prog[0] = ins(OP_CALL, 8'd4);
        prog[4] = ins(OP_CALL, 8'd6);
        prog[6] = ins(OP_CALL, 8'd9);
        load_and_clear();
        run = 1'b1;
        wait_halt("ovf_halt");
        check("ovf_fault", 32'(fault), 1);
        check("ovf_pc", 32'(pc), 6);

        // RET on empty stack, and an illegal opcode
        clear_prog();
        prog[0] = ins(OP_LDI, 8'd1);
        prog[1] = ins(OP_RET, 8'h00);
        load_and_clear();
        run = 1'b1;
        wait_halt("unf_halt");
        check("unf_fault", 32'(fault), 1);
        check("unf_pc", 32'(pc), 1);
        clear_prog();
        prog[0] = ins(5'h15, 8'h00);
        load_and_clear();
        run = 1'b1;
        wait_halt("ill_halt");
        check("ill_fault", 32'(fault), 1);
        check("ill_pc", 32'(pc), 0);

        // Output backpressure
        clear_prog();
        prog[0] = ins(OP_LDI, 8'h5A);
        prog[1] = ins(OP_OUT, 8'h00);
        prog[2] = ins(OP_LDI, 8'h11);
        load_and_clear();
        out_ready = 1'b0;
        run = 1'b1;
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_data", 32'(out_data), 32'h5A);
            check("bp_hold_busy", 32'(busy), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drop", 32'(out_valid), 0);
        wait_halt("bp_halt");
        check("bp_acc", 32'(acc), 32'h11);
        check("bp_pc", 32'(pc), 3);

        // Single step, and prog_we ignored while busy
        clear_prog();
        prog[0] = ins(OP_LDI, 8'd7);
        prog[1] = ins(OP_LDI, 8'd8);
        load_and_clear();
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("step_pc", 32'(pc), 1);
        check("step_acc", 32'(acc), 7);
        check("step_busy", 32'(busy), 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        prog_we    = 1'b1;
        prog_addr  = 4'd2;
        prog_wdata = ins(OP_LDI, 8'h99);
        tick();
        prog_we = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("step2_pc", 32'(pc), 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("busy_we_halted", 32'(halted), 1);
        check("busy_we_acc", 32'(acc), 8);

        // Asynchronous reset during OUT_WAIT; program memory survives
        clear_prog();
        prog[0] = ins(OP_LDI, 8'h33);
        prog[1] = ins(OP_OUT, 8'h00);
        load_and_clear();
        out_ready = 1'b0;
        run = 1'b1;
        wait_valid("ar_valid");
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 0);
        check("ar_acc", 32'(acc), 0);
        check("ar_pc", 32'(pc), 0);
        check("ar_busy", 32'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_halt("ar_halt");
        check("ar_rerun_acc", 32'(acc), 32'h33);
        check("ar_rerun_out", 32'(out_data), 32'h33);
        check("ar_rerun_pc", 32'(pc), 2);

        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
